// File: rtl/bcd_to_bin_ctrl.sv
// rtl/bcd_to_bin_ctrl.sv - reverse double-dabble BCD-to-binary control FSM and shift/correct datapath
// Optional invalid-digit detection is built when BCD_DIGIT_CHECK_EN is defined.
module bcd_to_bin_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bcd_in,
    input  logic        z,
    output logic        init,
    output logic        dec,
    output logic        busy,
    output logic        done,
    output logic [15:0] bin_out
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] sh, sh_nx;
    logic [15:0] bin_nx;

    // Shift the whole register right, then pull each BCD nibble that reached 8+ back by 3.
    function automatic logic [31:0] shift_correct(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        for (int i = 0; i < 4; i++) begin
            if (r[16 + 4*i + 3])
                r[16 + 4*i +: 4] = r[16 + 4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

`ifdef BCD_DIGIT_CHECK_EN
    logic err_nx;

    function automatic logic has_bad_digit(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            bad = bad | (v[4*i + 3] & (v[4*i + 2] | v[4*i + 1]));
        return bad;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            sh      <= 32'h0;
            bin_out <= 16'h0;
`ifdef BCD_DIGIT_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            sh      <= sh_nx;
            bin_out <= bin_nx;
`ifdef BCD_DIGIT_CHECK_EN
            err     <= err_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        bin_nx   = bin_out;
`ifdef BCD_DIGIT_CHECK_EN
        err_nx   = err;
`endif
        init     = 1'b0;
        dec      = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
                    if (has_bad_digit(bcd_in)) begin
                        state_nx = DONE;
                        bin_nx   = 16'h0;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = LOAD;
                        sh_nx    = {bcd_in, 16'h0};
                        err_nx   = 1'b0;
                    end
`else
                    state_nx = LOAD;
                    sh_nx    = {bcd_in, 16'h0};
`endif
                end
            end
            LOAD: begin
                init     = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                // z is the counter's registered terminal flag, so it is safe to gate dec with it.
                if (!z) begin
                    dec   = 1'b1;
                    sh_nx = shift_correct(sh);
                end else begin
                    bin_nx   = sh[15:0];
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcd_to_bin_ctrl.sv
// tb/tb_bcd_to_bin_ctrl.sv - self-checking bench for bcd_to_bin_ctrl with an iteration-counter model
module tb_bcd_to_bin_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        z = 1'b0;
    logic        init, dec, busy, done;
    logic [15:0] bin_out;
`ifdef BCD_DIGIT_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [4:0]  cnt = 5'd0;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    bcd_to_bin_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bcd_in(bcd_in),
        .z(z),
        .init(init),
        .dec(dec),
        .busy(busy),
        .done(done),
        .bin_out(bin_out)
`ifdef BCD_DIGIT_CHECK_EN
        ,
        .err(err)
`endif
    );

    // 5-bit iteration counter: reload 16, z registered on the edge applying the 16th dec.
    always @(posedge clk) begin
        if (init) begin
            cnt <= 5'd16;
            z   <= 1'b0;
        end else if (dec) begin
            cnt <= cnt - 5'd1;
            z   <= (cnt == 5'd1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (init || dec)) begin
            checks++;
            if ((init && dec) || (dec && !busy)) begin
                failures++;
                $display("FAIL strobe_excl: init=%0b dec=%0b busy=%0b", init, dec, busy);
            end
        end
    end

    task automatic wait_accept(output logic ok);
        logic was_idle;
        ok = 1'b0;
        for (int w = 0; w < 60; w++) begin
            was_idle = !busy;
            @(posedge clk);
            if (was_idle) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: got busy expected idle");
        end
    endtask

    task automatic conv(input logic [15:0] v, input logic [15:0] e, input logic hold,
                        input logic [15:0] v2, input int abort_at);
        int n, ninit, ndec;
        logic ok, got;
        logic [15:0] exp_val;
        start  = 1'b1;
        bcd_in = v;
        wait_accept(ok);
        if (!ok) return;
        exp_q.push_back(e);
        #1;
        if (!hold) start = 1'b0;
        n = 0; ninit = 0; ndec = 0; got = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            if (hold && n == 5) bcd_in = v2;
            if (n == abort_at) begin
                rst = 1'b0;
                start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("reset_outputs", {11'h0, busy, done, init, dec, bin_out}, 32'h0);
                @(posedge clk);
                #1 rst = 1'b1;
                exp_q.delete();
                return;
            end
            ninit += int'(init);
            ndec  += int'(dec);
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        chk("done_seen", {31'h0, got}, 32'h1);
        chk("latency", n, 18);
        chk("init_count", ninit, 1);
        chk("dec_count", ndec, 16);
        exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("bin_out", {16'h0, bin_out}, {16'h0, exp_val});
`ifdef BCD_DIGIT_CHECK_EN
        chk("err_valid", {31'h0, err}, 32'h0);
`endif
    endtask

    initial begin
        logic ok;
        vecs[0] = '{16'h0000, 16'h0000};
        vecs[1] = '{16'h9999, 16'h270F};
        vecs[2] = '{16'h1234, 16'h04D2};
        vecs[3] = '{16'h0001, 16'h0001};
        vecs[4] = '{16'h8000, 16'h1F40};
        vecs[5] = '{16'h0999, 16'h03E7};
        vecs[6] = '{16'h5555, 16'h15B3};
        vecs[7] = '{16'h2048, 16'h0800};
        vecs[8] = '{16'h0042, 16'h002A};
        vecs[9] = '{16'h0050, 16'h0032};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {11'h0, busy, done, init, dec, bin_out}, 32'h0);
`ifdef BCD_DIGIT_CHECK_EN
        chk("reset_err", {31'h0, err}, 32'h0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Consecutive calls re-raise start during the done cycle, so these run back-to-back.
        for (int i = 0; i < 10; i++)
            conv(vecs[i].bcd, vecs[i].exp, 1'b0, 16'h0, -1);

        // start held high, operand changed mid-conversion: captured value wins, next run waits.
        conv(16'h1234, 16'h04D2, 1'b1, 16'h0999, -1);
        conv(16'h0999, 16'h03E7, 1'b0, 16'h0, -1);

        // Reset in SHIFT cycle 8, then a full fresh conversion.
        conv(16'h1234, 16'h04D2, 1'b0, 16'h0, 8);
        @(negedge clk);
        conv(16'h0042, 16'h002A, 1'b0, 16'h0, -1);

`ifdef BCD_DIGIT_CHECK_EN
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h12A4;
        wait_accept(ok);
        #1 start = 1'b0;
        @(negedge clk);
        chk("bad_done", {31'h0, done}, 32'h1);
        chk("bad_err", {31'h0, err}, 32'h1);
        chk("bad_bin", {16'h0, bin_out}, 32'h0);
        chk("bad_strobes", {30'h0, init, dec}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bad_strobes_after", {30'h0, init, dec}, 32'h0);
        conv(16'h0050, 16'h0032, 1'b0, 16'h0, -1);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
